// File: rtl/mdu_if.sv
// Operand/result bus between the EX stage and the multiply/divide unit.
// Master drives operands and opcode; slave (the MDU) returns Busy, HI/LO and read data.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    modport master (
        output A, B, MDUOp, Start,
        input  Busy, HI, LO, MDUOut
    );

    modport slave (
        input  A, B, MDUOp, Start,
        output Busy, HI, LO, MDUOut
    );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at launch into holding registers and committed to HI/LO
// when the busy countdown expires, so latency is purely a timing model.
// Optional feature: define MDU_FLUSH_EN to add a Flush input that cancels an
// in-flight op and suppresses any same-cycle launch or MTHI/MTLO.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
`ifdef MDU_FLUSH_EN
    input  logic  Flush,
`endif
    mdu_if.slave  bus
);
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    logic flush;
`ifdef MDU_FLUSH_EN
    assign flush = Flush;
`else
    assign flush = 1'b0;
`endif

    logic        busy_q, busy_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_t_q, hi_t_d;
    logic [31:0] lo_t_q, lo_t_d;
    logic        wr_q, wr_d;  // holding regs carry a result to commit (clear on divide by zero)

    logic        is_mul, is_div, launch;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, divisor, q_mag, r_mag, quot, rem;

    // Arithmetic on the live operands; only latched on the launch edge.
    always_comb begin
        is_mul  = (bus.MDUOp == OpMult) || (bus.MDUOp == OpMultu);
        is_div  = (bus.MDUOp == OpDiv) || (bus.MDUOp == OpDivu);
        launch  = bus.Start && !busy_q && (is_mul || is_div);
        prod_u  = {32'b0, bus.A} * {32'b0, bus.B};
        prod_s  = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
        abs_a   = (bus.MDUOp == OpDiv && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
        abs_b   = (bus.MDUOp == OpDiv && bus.B[31]) ? (32'd0 - bus.B) : bus.B;
        divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag   = abs_a / divisor;
        r_mag   = abs_a % divisor;
        quot    = (bus.MDUOp == OpDiv && (bus.A[31] ^ bus.B[31])) ? (32'd0 - q_mag) : q_mag;
        rem     = (bus.MDUOp == OpDiv && bus.A[31]) ? (32'd0 - r_mag) : r_mag;
    end

    // Next-state: flush cancels, busy counts down and commits, idle launches or moves to HI/LO.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        hi_t_d = hi_t_q;
        lo_t_d = lo_t_q;
        wr_d   = wr_q;
        if (flush) begin
            busy_d = 1'b0;
            cnt_d  = 32'd0;
        end else if (busy_q) begin
            cnt_d = cnt_q - 32'd1;
            if (cnt_q == 32'd1) begin
                busy_d = 1'b0;
                if (wr_q) begin
                    hi_d = hi_t_q;
                    lo_d = lo_t_q;
                end
            end
        end else if (launch) begin
            busy_d = 1'b1;
            cnt_d  = is_mul ? MULT_CYCLES : DIV_CYCLES;
            wr_d   = is_mul || (bus.B != 32'd0);
            if (bus.MDUOp == OpMult) begin
                hi_t_d = prod_s[63:32];
                lo_t_d = prod_s[31:0];
            end else if (bus.MDUOp == OpMultu) begin
                hi_t_d = prod_u[63:32];
                lo_t_d = prod_u[31:0];
            end else begin
                hi_t_d = rem;
                lo_t_d = quot;
            end
        end else if (bus.MDUOp == OpMthi) begin
            hi_d = bus.A;
        end else if (bus.MDUOp == OpMtlo) begin
            lo_d = bus.A;
        end
    end

    // State registers with synchronous reset that overrides any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            hi_t_q <= 32'd0;
            lo_t_q <= 32'd0;
            wr_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            hi_t_q <= hi_t_d;
            lo_t_q <= lo_t_d;
            wr_q   <= wr_d;
        end
    end

    // Read port is combinational and returns stale HI/LO while busy.
    always_comb begin
        bus.MDUOut = 32'd0;
        if (bus.MDUOp == OpMfhi) begin
            bus.MDUOut = hi_q;
        end else if (bus.MDUOp == OpMflo) begin
            bus.MDUOut = lo_q;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule
